// File: rtl/tetris_pkg.sv
// Shared types and helpers for the Tetris executor path.
package tetris_pkg;

  localparam int piece_rows_gp = 4;
  localparam int piece_cols_gp = 4;

  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eTest  = 2'd1,
    eMerge = 2'd2,
    eDone  = 2'd3
  } executor_merge_state_e;

  // Row r of a 4x4 piece bitmap is the nibble at bits [4r+3:4r].
  function automatic logic [piece_cols_gp-1:0] piece_row(
    input logic [piece_rows_gp*piece_cols_gp-1:0] piece,
    input logic [1:0]                             r
  );
    return piece[{r, 2'b00} +: piece_cols_gp];
  endfunction

endpackage

// File: rtl/piece_row_align.sv
// Places one piece row at column x of matrix row y+r and flags out-of-bounds.
module piece_row_align
  import tetris_pkg::*;
#(
  parameter int width_p  = 16,
  parameter int height_p = 32
) (
  input  logic [piece_cols_gp-1:0]    row_i,
  input  logic [$clog2(width_p)-1:0]  x_i,
  input  logic [$clog2(height_p):0]   row_idx_i,
  output logic [width_p-1:0]          aligned_o,
  output logic                        oob_right_o,
  output logic                        oob_bottom_o
);

  localparam int rw_lp = $clog2(height_p) + 1;
  localparam logic [rw_lp-1:0] height_lp = rw_lp'(height_p);

  logic [width_p+piece_cols_gp-1:0] wide_s;

  assign wide_s       = {{width_p{1'b0}}, row_i} << x_i;
  assign aligned_o    = wide_s[width_p-1:0];
  assign oob_right_o  = |wide_s[width_p+piece_cols_gp-1:width_p];
  assign oob_bottom_o = (row_idx_i >= height_lp);

endmodule

// File: rtl/executor_merge.sv
// Tests a 4x4 piece against the matrix one row per cycle and, in merge mode,
// locks it into the matrix by read-modify-write.
module executor_merge
  import tetris_pkg::*;
#(
  parameter int width_p  = 16,
  parameter int height_p = 32,
  parameter int debug_p  = 0
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        v_i,
  output logic                        ready_o,
  input  logic                        mode_i,
  input  logic [15:0]                 piece_i,
  input  logic [$clog2(width_p)-1:0]  pos_x_i,
  input  logic [$clog2(height_p)-1:0] pos_y_i,
  output logic                        done_o,
  output logic                        collision_o,
  output logic                        merged_o,
  output logic [$clog2(height_p)-1:0] mm_read_addr_o,
  input  logic [width_p-1:0]          mm_read_data_i,
  output logic [$clog2(height_p)-1:0] mm_write_addr_o,
  output logic [width_p-1:0]          mm_write_data_o,
  output logic                        mm_write_v_o
);

  localparam int xw_lp = $clog2(width_p);
  localparam int yw_lp = $clog2(height_p);

  executor_merge_state_e state_r;
  logic                  mode_r;
  logic [15:0]           piece_r;
  logic [xw_lp-1:0]      x_r;
  logic [yw_lp-1:0]      y_r;
  logic [1:0]            row_cnt_r;
  logic                  coll_r;

  logic [piece_cols_gp-1:0] row_s;
  logic [yw_lp:0]           row_idx_s;
  logic [width_p-1:0]       aligned_s;
  logic                     oob_right_s;
  logic                     oob_bottom_s;
  logic                     row_nz_s;
  logic                     row_coll_s;

  assign row_s     = piece_row(piece_r, row_cnt_r);
  assign row_idx_s = {1'b0, y_r} + {{(yw_lp-1){1'b0}}, row_cnt_r};
  assign row_nz_s  = |row_s;

  piece_row_align #(
    .width_p  (width_p),
    .height_p (height_p)
  ) u_align (
    .row_i        (row_s),
    .x_i          (x_r),
    .row_idx_i    (row_idx_s),
    .aligned_o    (aligned_s),
    .oob_right_o  (oob_right_s),
    .oob_bottom_o (oob_bottom_s)
  );

  assign row_coll_s = row_nz_s &&
                      (oob_bottom_s || oob_right_s || (|(aligned_s & mm_read_data_i)));

  assign ready_o         = (state_r == eIDLE);
  assign mm_read_addr_o  = row_idx_s[yw_lp-1:0];
  assign mm_write_addr_o = row_idx_s[yw_lp-1:0];
  assign mm_write_data_o = mm_read_data_i | aligned_s;
  // Gated by reset_i so an abort cannot commit the row being written that cycle.
  assign mm_write_v_o    = (state_r == eMerge) && row_nz_s && !oob_bottom_s &&
                           !oob_right_s && !reset_i;

  // Control FSM: accept, per-row test, per-row merge, completion pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= eIDLE;
      mode_r      <= 1'b0;
      piece_r     <= 16'h0000;
      x_r         <= '0;
      y_r         <= '0;
      row_cnt_r   <= 2'd0;
      coll_r      <= 1'b0;
      done_o      <= 1'b0;
      collision_o <= 1'b0;
      merged_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_r)
        eIDLE: begin
          if (v_i) begin
            mode_r      <= mode_i;
            piece_r     <= piece_i;
            x_r         <= pos_x_i;
            y_r         <= pos_y_i;
            row_cnt_r   <= 2'd0;
            coll_r      <= 1'b0;
            collision_o <= 1'b0;
            merged_o    <= 1'b0;
            state_r     <= eTest;
          end
        end
        eTest: begin
          row_cnt_r <= row_cnt_r + 2'd1;
          coll_r    <= coll_r | row_coll_s;
          if (row_cnt_r == 2'd3) begin
            if (coll_r || row_coll_s || !mode_r) begin
              collision_o <= coll_r | row_coll_s;
              done_o      <= 1'b1;
              state_r     <= eDone;
            end else begin
              row_cnt_r <= 2'd0;
              state_r   <= eMerge;
            end
          end
        end
        eMerge: begin
          row_cnt_r <= row_cnt_r + 2'd1;
          if (row_cnt_r == 2'd3) begin
            merged_o    <= 1'b1;
            collision_o <= coll_r;
            done_o      <= 1'b1;
            state_r     <= eDone;
          end
        end
        eDone: begin
          state_r <= eIDLE;
        end
        default: begin
          state_r <= eIDLE;
        end
      endcase
    end
  end

  // debug_p selects the per-cycle state trace provided by the bound checker.
  if (debug_p != 0) begin : g_debug
  end

endmodule

// File: tb/tb_executor_merge.sv
// Randomized self-checking bench for executor_merge with a matrix model.
module tb_executor_merge;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic        ready_o;
  logic        mode_i;
  logic [15:0] piece_i;
  logic [3:0]  pos_x_i;
  logic [4:0]  pos_y_i;
  logic        done_o;
  logic        collision_o;
  logic        merged_o;
  logic [4:0]  mm_read_addr_o;
  logic [15:0] mm_read_data_i;
  logic [4:0]  mm_write_addr_o;
  logic [15:0] mm_write_data_o;
  logic        mm_write_v_o;

  logic [15:0] mem [0:31];
  logic [15:0] ref_mem [0:31];
  logic [20:0] wq[$];
  logic        clr_v = 1'b0;
  logic        pl_v = 1'b0;
  logic [4:0]  pl_addr = 5'd0;
  logic [15:0] pl_data = 16'h0000;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk_i = ~clk_i;

  executor_merge #(.width_p(16), .height_p(32), .debug_p(0)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .mode_i(mode_i), .piece_i(piece_i), .pos_x_i(pos_x_i), .pos_y_i(pos_y_i),
    .done_o(done_o), .collision_o(collision_o), .merged_o(merged_o),
    .mm_read_addr_o(mm_read_addr_o), .mm_read_data_i(mm_read_data_i),
    .mm_write_addr_o(mm_write_addr_o), .mm_write_data_o(mm_write_data_o),
    .mm_write_v_o(mm_write_v_o)
  );

  assign mm_read_data_i = mem[mm_read_addr_o];

  // Matrix memory: bench clear/preload port plus DUT write port, with write log.
  always @(posedge clk_i) begin
    if (clr_v) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'h0000;
    end else if (pl_v) begin
      mem[pl_addr] <= pl_data;
    end else if (mm_write_v_o) begin
      mem[mm_write_addr_o] <= mm_write_data_o;
      wq.push_back({mm_write_addr_o, mm_write_data_o});
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    @(negedge clk_i); clr_v = 1'b1;
    @(negedge clk_i); clr_v = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 16'h0000;
  endtask

  task automatic preload(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk_i); pl_v = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk_i); pl_v = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic mem_compare(input string tag);
    int bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk_eq(tag, bad, 0);
  endtask

  // Issue one request; the model decides the outcome from the placement rules.
  task automatic do_op(input string tag, input logic [15:0] pc, input int x, input int y,
                       input bit md, input bit poke);
    bit        coll = 1'b0;
    int        lat;
    int        g;
    int        row, yy, wide;
    logic [20:0] exp_w[$];
    for (int r = 0; r < 4; r++) begin
      row  = (pc >> (4 * r)) & 15;
      yy   = y + r;
      wide = row << x;
      if (row != 0) begin
        if (yy >= 32 || (wide >> 16) != 0) coll = 1'b1;
        else if ((wide & ref_mem[yy]) != 0) coll = 1'b1;
      end
    end
    if (!coll && md) begin
      for (int r = 0; r < 4; r++) begin
        row  = (pc >> (4 * r)) & 15;
        yy   = y + r;
        wide = row << x;
        if (row != 0) begin
          ref_mem[yy] = ref_mem[yy] | wide[15:0];
          exp_w.push_back({yy[4:0], ref_mem[yy]});
        end
      end
    end
    wq.delete();
    g = 0;
    while (!ready_o && g < 20) begin @(negedge clk_i); g++; end
    chk_eq({tag, " ready"}, ready_o, 1'b1);
    v_i = 1'b1; piece_i = pc; pos_x_i = x[3:0]; pos_y_i = y[4:0]; mode_i = md;
    @(posedge clk_i);
    @(negedge clk_i);
    v_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 20) begin
      if (poke && lat == 2) begin
        v_i = 1'b1; piece_i = 16'($urandom); mode_i = 1'b1;
      end else begin
        v_i = 1'b0;
      end
      @(negedge clk_i);
      lat++;
    end
    v_i = 1'b0;
    chk_eq({tag, " done"}, done_o, 1'b1);
    chk_eq({tag, " latency"}, lat, (!coll && md) ? 9 : 5);
    chk_eq({tag, " collision"}, collision_o, coll);
    chk_eq({tag, " merged"}, merged_o, !coll && md);
    chk_eq({tag, " nwrites"}, wq.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wq.size(); i++)
      chk_eq({tag, " write"}, wq[i], exp_w[i]);
    @(negedge clk_i);
    chk_eq({tag, " done_pulse"}, done_o, 1'b0);
    chk_eq({tag, " held_coll"}, collision_o, coll);
    mem_compare({tag, " mem"});
  endtask

  initial begin
    int lat;
    reset_i = 1'b1; v_i = 1'b0; mode_i = 1'b0; piece_i = 16'h0000;
    pos_x_i = 4'd0; pos_y_i = 5'd0;
    clear_mem();
    repeat (2) @(negedge clk_i);
    chk_eq("rst ready", ready_o, 1'b1);
    chk_eq("rst outs", {done_o, collision_o, merged_o, mm_write_v_o}, 4'b0000);
    chk_eq("rst addrs", {mm_read_addr_o, mm_write_addr_o}, 10'd0);
    reset_i = 1'b0;

    do_op("fit_merge", 16'h0033, 3, 30, 1'b1, 1'b0);
    chk_eq("row30", mem[30], 16'h0018);
    chk_eq("row31", mem[31], 16'h0018);
    clear_mem();
    preload(5'd31, 16'h0010);
    do_op("mem_coll", 16'h0033, 3, 30, 1'b1, 1'b0);
    clear_mem();
    do_op("oob_right", 16'h0033, 15, 0, 1'b1, 1'b0);
    do_op("oob_bottom", 16'h0033, 0, 31, 1'b1, 1'b0);
    do_op("bottom_fit", 16'h000F, 0, 31, 1'b1, 1'b0);
    chk_eq("row31_f", mem[31], 16'h000F);
    do_op("test_only", 16'h0660, 5, 10, 1'b0, 1'b1);
    do_op("empty_piece", 16'h0000, 7, 20, 1'b1, 1'b0);

    // Abort on the second merge cycle: only row 0 may be written.
    clear_mem();
    wq.delete();
    @(negedge clk_i);
    v_i = 1'b1; piece_i = 16'h1111; pos_x_i = 4'd0; pos_y_i = 5'd0; mode_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    v_i = 1'b0;
    lat = 1;
    while (lat < 6) begin @(negedge clk_i); lat++; end
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    chk_eq("abort nwrites", wq.size(), 1);
    chk_eq("abort row0", mem[0], 16'h0001);
    chk_eq("abort row1", mem[1], 16'h0000);
    chk_eq("abort outs", {done_o, collision_o, merged_o, mm_write_v_o}, 4'b0000);
    chk_eq("abort ready", ready_o, 1'b1);
    ref_mem[0] = 16'h0001;

    for (int n = 0; n < 40; n++) begin
      logic [15:0] pc;
      if (n % 8 == 0) begin
        clear_mem();
        for (int k = 0; k < 6; k++)
          preload(5'($urandom_range(31, 0)), 16'($urandom & $urandom & $urandom));
      end
      pc = (n % 3 == 0) ? 16'($urandom & $urandom) : 16'($urandom);
      do_op("rand", pc, $urandom_range(15, 0), $urandom_range(31, 0),
            1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/executor_merge.md
Name: executor_merge

Overview:
- Upstream neighbour of the line-clear checker in the Tetris executor path.
- Takes a 4x4 piece bitmap and its position, then tests it against the matrix memory for overlap and out-of-bounds.
- In merge mode it then locks the piece into the matrix by read-modify-write.
- done_o/merged_o from this block trigger the line-clear check that follows.

Parameters:
width_p, 16, matrix columns (bits per row word)
height_p, 32, matrix rows; row 0 top, row height_p-1 bottom
debug_p, 0, nonzero enables per-cycle $display of state/row counter

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
v_i  in  1  request; accepted only when ready_o=1
ready_o  out  1  high in eIDLE
mode_i  in  1  0=test only, 1=test then merge
piece_i  in  16  bitmap; row r = bits[4r+3:4r], bit c = column offset c
pos_x_i  in  $clog2(width_p)  column of piece bit 0
pos_y_i  in  $clog2(height_p)  matrix row of piece row 0
done_o  out  1  one-cycle pulse, operation finished
collision_o  out  1  result of last test; valid from done_o, held until next accept
merged_o  out  1  last op wrote the piece; held like collision_o
mm_read_addr_o  out  $clog2(height_p)  matrix read address; combinational read, data same cycle
mm_read_data_i  in  width_p  matrix read data
mm_write_addr_o  out  $clog2(height_p)  matrix write address
mm_write_data_o  out  width_p  matrix write data
mm_write_v_o  out  1  write strobe

Behaviour:
- Reset values: state eIDLE; done_o, collision_o, merged_o, mm_write_v_o all 0; read/write addresses 0.
- Reset mid-operation aborts immediately. No further writes; writes already done are not undone. ready_o=1 on the next cycle.
- States: eIDLE, eTest, eMerge, eDone.
- eIDLE + v_i: latch mode, piece, x, y; clear collision_o and merged_o; row_cnt<=0; go to eTest.
- v_i is ignored outside eIDLE.
- Row r alignment (shared by eTest and eMerge):
  - aligned = {piece row r, zero-extended to width_p+4} << x.
  - Bits at index >= width_p are out-of-bounds right.
  - Row index y+r is computed in $clog2(height_p)+1 bits; y+r >= height_p is out-of-bounds bottom.
- eTest, one row per cycle, r = 0..3, mm_read_addr_o = y+r:
  - A row is colliding if it is nonzero and any of: OOB bottom, OOB right bits, or (aligned[width_p-1:0] & mm_read_data_i) != 0.
  - Rows that are zero or OOB bottom never collide on memory data.
  - Sticky collision accumulator.
- At r=3 in eTest: if collision or mode=0, go to eDone; otherwise row_cnt<=0 and go to eMerge.
- eMerge, r = 0..3:
  - mm_read_addr_o = mm_write_addr_o = y+r.
  - mm_write_data_o = mm_read_data_i | aligned[width_p-1:0].
  - mm_write_v_o = 1 only if piece row r is nonzero; it is never asserted for an OOB row.
  - At r=3 set merged_o and go to eDone.
- eDone: done_o=1 for one cycle; collision_o reflects the accumulator; then eIDLE.
- Latency from accept cycle: test-only or collision → done_o 5 cycles later; successful merge → 9 cycles later.
- Writes occur strictly in ascending row order, at most one per cycle.
- mm_write_v_o is 0 in every state other than eMerge.
- Piece 16'h0000: no collision; merge performs 0 writes; merged_o=1.

Decomposition:
- Shared package tetris_pkg:
  - executor_merge_state_e enum {eIDLE, eTest, eMerge, eDone}.
  - Constants piece_rows_gp=4, piece_cols_gp=4.
  - Piece row slicing function.
- One sub-module, piece_row_align:
  - Combinational; inputs piece row, x, y+r.
  - Outputs aligned row, oob_right, oob_bottom.
  - Instantiated once and shared by both phases.

Test Plan:
- width_p=16, height_p=32, empty matrix; piece 16'h0033, x=3, y=30, mode=1 → writes row30=16'h0018 then row31=16'h0018; collision_o=0, merged_o=1; done_o 9 cycles after accept.
- Same piece, row31 preloaded 16'h0010, mode=1 → collision_o=1, merged_o=0, zero writes; done_o 5 cycles after accept.
- Piece 16'h0033, x=15, y=0 (bit1 maps to column 16) → collision_o=1, no writes.
- Piece 16'h0033, y=31 (row 1 maps to row 32) → collision_o=1. Piece 16'h000F, y=31 (upper rows zero) mode=1 → row31 |= 16'h000F, collision_o=0.
- mode=0 on a fitting piece → collision_o=0, merged_o=0, mm_write_v_o never high. A v_i pulse during eTest is ignored.
- reset_i asserted on the 2nd eMerge cycle of piece 16'h1111 at y=0 → exactly 1 write (row0), all outputs 0 next cycle, ready_o=1.
